// File: rtl/apu_pkg.sv
// apu_pkg: shared widths, thresholds and sweep register layout for the APU pulse channels
package apu_pkg;
   localparam int APU_PERIOD_W        = 11;
   localparam int APU_MUTE_MIN_PERIOD = 8;
   typedef struct packed {
      logic       en;
      logic [2:0] period;
      logic       neg;
      logic [2:0] shift;
   } sweep_reg_t;
endpackage

// File: rtl/apu_sweep_target.sv
// apu_sweep_target: combinational sweep target period; shared by both pulse channels
module apu_sweep_target
   import apu_pkg::*;
#(
   parameter bit ONES_COMPLEMENT = 1'b1
) (
   input  logic [APU_PERIOD_W-1:0] i_period,
   input  logic [2:0]              i_shift,
   input  logic                    i_negate,
   output logic [APU_PERIOD_W:0]   o_target,
   output logic                    o_overflow
);
   logic [APU_PERIOD_W-1:0] w_delta;
   logic [APU_PERIOD_W+1:0] w_diff;
   assign w_delta = i_period >> i_shift;
   // one extra bit so a borrow below zero is visible and can saturate to 0
   assign w_diff = {2'b00, i_period} - {2'b00, w_delta} - {{(APU_PERIOD_W+1){1'b0}}, ONES_COMPLEMENT};
   assign o_target = i_negate ? (w_diff[APU_PERIOD_W+1] ? '0 : w_diff[APU_PERIOD_W:0])
                              : {1'b0, i_period} + {1'b0, w_delta};
   assign o_overflow = !i_negate & o_target[APU_PERIOD_W];
endmodule

// File: rtl/apu_pulse_sweep.sv
// apu_pulse_sweep: pulse channel period register, sweep unit and timer load interface.
// APU_SWEEP_MUTE_EN enables the mute output; otherwise mute is 0 and only overflow blocks sweeps.
module apu_pulse_sweep
   import apu_pkg::*;
#(
   parameter bit ONES_COMPLEMENT = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    half_frame,
   input  logic                    sweep_wr,
   input  logic [7:0]              sweep_data,
   input  logic                    period_lo_wr,
   input  logic                    period_hi_wr,
   input  logic [7:0]              period_data,
   output logic                    timer_load,
   output logic [APU_PERIOD_W-1:0] timer_data_out,
   output logic                    mute
);
   sweep_reg_t              r_sweep;
   logic [APU_PERIOD_W-1:0] r_period, r_tdo, w_base, w_period_nxt;
   logic [2:0]              r_div;
   logic                    r_reload, r_load, r_mute;
   logic [APU_PERIOD_W:0]   w_target;
   logic                    w_overflow, w_mute, w_block, w_div_zero, w_sweep;

   apu_sweep_target #(.ONES_COMPLEMENT(ONES_COMPLEMENT)) u_target (
      .i_period   (r_period),
      .i_shift    (r_sweep.shift),
      .i_negate   (r_sweep.neg),
      .o_target   (w_target),
      .o_overflow (w_overflow)
   );

`ifdef APU_SWEEP_MUTE_EN
   localparam bit MUTE_RST = 1'b1;
   logic w_mute_cond;
   assign w_mute_cond = (r_period < APU_PERIOD_W'(APU_MUTE_MIN_PERIOD)) | w_overflow;
   assign w_mute      = w_mute_cond;
   assign w_block     = w_mute_cond;
`else
   localparam bit MUTE_RST = 1'b0;
   assign w_mute  = 1'b0;
   assign w_block = w_overflow;
`endif

   assign w_div_zero = (r_div == 3'd0);
   assign w_sweep    = half_frame & w_div_zero & r_sweep.en & (r_sweep.shift != 3'd0) & !w_block;
   // any CPU write discards the sweep result for both halves
   assign w_base       = (period_lo_wr | period_hi_wr | !w_sweep) ? r_period : w_target[APU_PERIOD_W-1:0];
   assign w_period_nxt = {period_hi_wr ? period_data[2:0] : w_base[10:8],
                          period_lo_wr ? period_data      : w_base[7:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sweep  <= '0;
         r_period <= '0;
         r_tdo    <= '0;
         r_div    <= '0;
         r_reload <= 1'b0;
         r_load   <= 1'b0;
         r_mute   <= MUTE_RST;
      end else begin
         r_period <= w_period_nxt;
         r_tdo    <= r_period;
         r_load   <= (r_period != r_tdo);
         r_mute   <= w_mute;
         if (sweep_wr) r_sweep <= sweep_reg_t'(sweep_data);
         if (sweep_wr) r_reload <= 1'b1;
         else if (half_frame && (w_div_zero || r_reload)) r_reload <= 1'b0;
         if (half_frame) r_div <= (w_div_zero || r_reload) ? r_sweep.period : r_div - 3'd1;
      end
   end

   assign timer_load     = r_load;
   assign timer_data_out = r_tdo;
   assign mute           = r_mute;
endmodule

// File: doc/apu_pulse_sweep.md
Name: apu_pulse_sweep

Overview:
Owns the 11-bit period of one APU pulse channel and drives the load side of the pulse timer.
- Applies CPU period writes ($4002/$4003 or $4006/$4007).
- Applies sweep adjustments on half-frame strobes ($4001/$4005 semantics).
- Presents the resulting period, with a one-cycle load strobe, to the pulse timer's timer_load/timer_data_in inputs.
- Computes the channel mute condition consumed by the pulse output mixer.

Parameters:
- ONES_COMPLEMENT, 1, 1 = pulse 1 negate (target = period - shifted - 1); 0 = pulse 2 negate (target = period - shifted).

Ports:
- clk  input  1  APU clock
- reset  input  1  asynchronous, active-high reset
- half_frame  input  1  one-cycle strobe from frame counter
- sweep_wr  input  1  one-cycle strobe: sweep register write
- sweep_data  input  8  {enable, period[2:0], negate, shift[2:0]}
- period_lo_wr  input  1  one-cycle strobe: period bits [7:0] write
- period_hi_wr  input  1  one-cycle strobe: period bits [10:8] write
- period_data  input  8  CPU data; hi write uses [2:0] only
- timer_load  output  1  one-cycle strobe: timer_data_out changed
- timer_data_out  output  11  current channel period
- mute  output  1  channel must be silenced

Behaviour:
- Reset (async): all outputs and state cleared.
  - period = 0, timer_data_out = 0, timer_load = 0.
  - Sweep fields = 0, divider = 0, reload flag = 0.
  - mute = 1, because period < 8.
- Registers, all updated on posedge clk:
  - period[10:0]
  - en, div_p[2:0], neg, sh[2:0]
  - divider[2:0]
  - reload
- sweep_wr:
  - Latch all fields from sweep_data.
  - Set reload = 1.
  - Does not touch period.
- period_lo_wr: period[7:0] <= period_data.
- period_hi_wr: period[10:8] <= period_data[2:0].
- Both period strobes in the same cycle: both halves are written.
- Target, combinational and 12-bit wide:
  - delta = period >> sh.
  - neg = 0: target = {0,period} + delta.
  - neg = 1: target = {0,period} - delta - ONES_COMPLEMENT, saturated at 0. With sh = 0 and pulse 1, the result saturates to 0.
- Mute condition: mute = (period < 8) | (!neg & target[11]). It is evaluated continuously, whether or not en is set.
- On a half_frame cycle:
  - Sweep update: if divider == 0, en, sh != 0 and !mute, then period <= target[10:0].
  - Divider: if divider == 0 or reload, then divider <= div_p and reload <= 0; otherwise divider <= divider - 1.
  - The sweep update uses divider, reload and sweep fields as they stood before this edge.
- Simultaneous events:
  - CPU period write and sweep update in the same cycle: the CPU write wins for the half(s) written.
  - A sweep update on a non-written half is discarded entirely; period takes CPU data for the written half and keeps its old value elsewhere.
  - sweep_wr coincident with half_frame:
    - The divider step uses the old reload value and the old div_p.
    - The new fields and reload = 1 take effect next cycle.
- Output pipeline:
  - timer_data_out is a register mirroring period with 1-cycle latency.
  - timer_load is asserted for exactly one cycle after any cycle in which period changed value. Writes of an identical value produce no strobe.
- mute: registered from the combinational condition, 1-cycle latency.
- Reset mid-operation: immediate return to reset values; no pending load strobe survives.

Optional Feature:
- APU_SWEEP_MUTE_EN
- Defined: mute behaves as above.
- Undefined:
  - mute is tied to 0.
  - The sweep update condition ignores mute but still blocks the write when target[11] is set, so period never wraps.

Decomposition:
- apu_pkg:
  - APU_PERIOD_W = 11
  - typedef struct packed sweep_reg_t {en, period[2:0], neg, shift[2:0]}
  - APU_MUTE_MIN_PERIOD = 8
- Sub-module apu_sweep_target: purely combinational.
  - Inputs: period, shift, negate, ONES_COMPLEMENT.
  - Outputs: 12-bit target and overflow.
  - Shared by both pulse channel instances.

Test Plan:
1. Reset, then check outputs: timer_data_out = 0, timer_load = 0, mute = 1.
2. period_lo_wr 0x40 then period_hi_wr 0x1:
   - period = 0x140.
   - One timer_load pulse per write, each in the cycle after the write.
   - mute = 0 after the first write.
3. period = 0x100, sweep_data = 0x81 (en, P = 0, up, sh = 1), two half_frames:
   - Period becomes 0x180, then 0x240.
   - timer_load pulses once after each.
4. period = 0x100, sweep_data = 0x89 (negate, sh = 1), one half_frame:
   - ONES_COMPLEMENT = 1 → 0x07F.
   - ONES_COMPLEMENT = 0 → 0x080.
5. period = 0x600, sweep_data = 0x01 (disabled, up, sh = 1):
   - target = 0x900 > 0x7FF, so mute = 1.
   - After a half_frame, period stays 0x600 and no timer_load pulse occurs.
6. sweep_data = 0xB1 (P = 3), period = 0x100:
   - period changes on half_frames 1, 5 and 9 only (divider reload each period).
   - period_lo_wr 0x00 coincident with half_frame 5 gives period 0x100, i.e. the CPU write wins and the high half keeps its old value.
